// File: rtl/spi_shift_pkg.sv
// Shared constants and FSM state encoding for the SPI shift master.
package spi_shift_pkg;
  localparam int OPCODE_W    = 4;
  localparam int FRAME_W     = 68;
  localparam int RESULT_BITS = 32;

  localparam logic [OPCODE_W-1:0] OP_SHL = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_SHR = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SHIFT_OUT,
    ST_GAP,
    ST_SHIFT_IN,
    ST_DESELECT,
    ST_DONE
  } state_t;
endpackage

// File: rtl/spi_if.sv
// Four-wire SPI bus between the shift master and the barrel-shifter slave.
interface spi_if;
  logic sclk;
  logic nss;
  logic mosi;
  logic miso;

  modport MASTER (output sclk, output nss, output mosi, input miso);
  modport SLAVE  (input sclk, input nss, input mosi, output miso);
endinterface

// File: rtl/spi_sclk_timer.sv
// SCLK generator: CLK_DIV system clocks per half-period, low phase first, with
// one-cycle strobes on the clock edges that drive SCLK high and low.
module spi_sclk_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic stop_i,
  output logic sclk_o,
  output logic rise_strobe_o,
  output logic fall_strobe_o
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             phase_end;

  // Strobes depend only on en_i and registers so the FSM can use them to pick
  // its next state without forming a combinational loop through stop_i.
  assign phase_end     = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign rise_strobe_o = phase_end && !sclk_q;
  assign fall_strobe_o = phase_end && sclk_q;
  assign sclk_o        = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i || stop_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (phase_end) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
endmodule

// File: rtl/spi_shift_master.sv
// SPI master: sends a 68-bit {opcode, A, B} frame MSB first, waits, reads a 32-bit result.
// Optional abort input / aborted_pulse output when SPI_SHIFT_MASTER_ABORT_EN is defined.
module spi_shift_master
  import spi_shift_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4,
  parameter int REG_WIDTH  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  // req: transfer on a rising edge with req_valid && req_ready; ready only in IDLE,
  // payload ignored otherwise. rsp_valid is a one-cycle pulse without back-pressure.
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OPCODE_W-1:0]  req_opcode,
  input  logic [REG_WIDTH-1:0] req_a,
  input  logic [REG_WIDTH-1:0] req_b,
  output logic                 rsp_valid,
  output logic [REG_WIDTH-1:0] rsp_result,
  output logic                 busy,
  output state_t               dbg_state,
`ifdef SPI_SHIFT_MASTER_ABORT_EN
  input  logic                 abort,
  output logic                 aborted_pulse,
`endif
  spi_if.MASTER                spi
);
  localparam int FRAME_BITS = OPCODE_W + 2 * REG_WIDTH;

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   frame_q;
  logic [REG_WIDTH-1:0]    shift_in_q;
  logic [REG_WIDTH-1:0]    rsp_result_q;
  logic [6:0]              bit_cnt_q;
  logic [15:0]             wait_cnt_q;
  logic                    shifting, timer_stop, rise, fall, abort_now;

`ifdef SPI_SHIFT_MASTER_ABORT_EN
  logic aborted_q;
  assign abort_now     = abort && (state_q != ST_IDLE);
  assign aborted_pulse = aborted_q;
`else
  assign abort_now = 1'b0;
`endif

  assign shifting   = (state_q == ST_SHIFT_OUT) || (state_q == ST_SHIFT_IN);
  // Any state change (end of shifting, abort) parks SCLK low on the same edge.
  assign timer_stop = (state_d != state_q);

  spi_sclk_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clock         (clock),
    .reset         (reset),
    .en_i          (shifting),
    .stop_i        (timer_stop),
    .sclk_o        (spi.sclk),
    .rise_strobe_o (rise),
    .fall_strobe_o (fall)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (req_valid) state_d = ST_SELECT;
      ST_SELECT:    if (wait_cnt_q == 16'(CLK_DIV - 1)) state_d = ST_SHIFT_OUT;
      ST_SHIFT_OUT: if (fall && bit_cnt_q == 7'(FRAME_BITS - 1)) state_d = ST_GAP;
      ST_GAP:       if (wait_cnt_q == 16'(GAP_CYCLES - 1)) state_d = ST_SHIFT_IN;
      ST_SHIFT_IN:  if (fall && bit_cnt_q == 7'(REG_WIDTH - 1)) state_d = ST_DESELECT;
      ST_DESELECT:  if (wait_cnt_q == 16'(CLK_DIV - 1)) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (abort_now) state_d = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      frame_q      <= '0;
      shift_in_q   <= '0;
      rsp_result_q <= '0;
      bit_cnt_q    <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q <= state_d;

      if (state_d != state_q) wait_cnt_q <= '0;
      else if (state_q inside {ST_SELECT, ST_GAP, ST_DESELECT}) wait_cnt_q <= wait_cnt_q + 16'd1;

      if (state_d != state_q) bit_cnt_q <= '0;
      else if (fall) bit_cnt_q <= bit_cnt_q + 7'd1;

      if (state_q == ST_IDLE && req_valid) frame_q <= {req_opcode, req_a, req_b};
      else if (state_q == ST_SHIFT_OUT && fall) frame_q <= frame_q << 1;

      // Result arrives MSB first; capture on the edge that raises SCLK.
      if (state_q == ST_SHIFT_IN && rise) shift_in_q <= {shift_in_q[REG_WIDTH-2:0], spi.miso};

      if (state_q == ST_DESELECT && state_d == ST_DONE) rsp_result_q <= shift_in_q;
    end
  end

`ifdef SPI_SHIFT_MASTER_ABORT_EN
  always_ff @(posedge clock) begin
    if (reset) aborted_q <= 1'b0;
    else       aborted_q <= abort_now;
  end
`endif

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_result = rsp_result_q;
  assign dbg_state  = state_q;
  assign spi.nss    = !(state_q inside {ST_SELECT, ST_SHIFT_OUT, ST_GAP, ST_SHIFT_IN});
  assign spi.mosi   = (state_q == ST_SHIFT_OUT) && frame_q[FRAME_BITS-1];
endmodule

// File: tb/tb_spi_shift_master.sv
// Directed bench for spi_shift_master with a sampling barrel-shifter slave on the bus.
// Define SPI_SHIFT_MASTER_ABORT_EN for both DUT and bench to exercise abort.
module tb_spi_shift_master;
  import spi_shift_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_opcode = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic [31:0] rsp_result;
  logic        busy;
  state_t      dbg_state;
`ifdef SPI_SHIFT_MASTER_ABORT_EN
  logic        abort = 1'b0;
  logic        aborted_pulse;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  spi_if spi ();

  spi_shift_master #(.CLK_DIV(4), .GAP_CYCLES(4), .REG_WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .busy       (busy),
    .dbg_state  (dbg_state),
`ifdef SPI_SHIFT_MASTER_ABORT_EN
    .abort         (abort),
    .aborted_pulse (aborted_pulse),
`endif
    .spi        (spi)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- barrel-shifter slave (samples SCLK with the system clock) ----------------
  logic        s_sclk_prev = 1'b0;
  logic [67:0] s_in_sr = '0;
  int          s_in_cnt = 0;
  logic [31:0] s_out_sr = '0;
  logic        s_started = 1'b0;
  logic [31:0] s_res;

  function automatic logic [31:0] slave_calc(input logic [67:0] f);
    logic [3:0]  op;
    logic [31:0] a, b;
    {op, a, b} = f;
    case (op)
      OP_SHL:  return a << b[4:0];
      OP_SHR:  return a >> b[4:0];
      default: return a;
    endcase
  endfunction

  always @(posedge clock) begin
    s_sclk_prev <= spi.sclk;
    if (spi.nss !== 1'b0) begin
      s_in_cnt  <= 0;
      s_started <= 1'b0;
      spi.miso  <= 1'b0;
    end else if (spi.sclk && !s_sclk_prev) begin
      if (s_in_cnt < 68) begin
        s_in_sr  <= {s_in_sr[66:0], spi.mosi};
        s_in_cnt <= s_in_cnt + 1;
        if (s_in_cnt == 67) begin
          s_res = slave_calc({s_in_sr[66:0], spi.mosi});
          s_out_sr <= s_res;
          spi.miso <= s_res[31];
        end
      end else begin
        s_started <= 1'b1;
      end
    end else if (!spi.sclk && s_sclk_prev && s_started) begin
      s_out_sr <= s_out_sr << 1;
      spi.miso <= s_out_sr[30];
    end
  end

  // ---------------- event counters ----------------
  logic mon_sclk_prev = 1'b0;
  int   rise_total = 0;
  int   rsp_total  = 0;

  always @(posedge clock) begin
    mon_sclk_prev <= spi.sclk;
    if (spi.sclk === 1'b1 && mon_sclk_prev === 1'b0) rise_total <= rise_total + 1;
    if (rsp_valid === 1'b1) rsp_total <= rsp_total + 1;
  end

  // ---------------- driver ----------------
  // Cycle 0 is the cycle in which req_valid && req_ready is presented; the
  // negedge after the acceptance edge is cycle 1.
  task automatic do_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int rises);
    int cyc;
    int r0;
    @(negedge clock);
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
    cyc = 0;
    while (!req_ready && cyc < 100) begin @(negedge clock); cyc++; end
    r0 = rise_total;
    @(negedge clock);
    req_valid = 1'b0;
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 2000) begin @(negedge clock); cyc++; end
    lat   = (rsp_valid === 1'b1) ? cyc : -1;
    res   = rsp_result;
    rises = rise_total - r0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_tests++; if (spi.sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", spi.sclk); end
    n_tests++; if (spi.nss !== 1'b1) begin n_fail++; $display("FAIL reset_nss: got %b expected 1", spi.nss); end
    n_tests++; if (spi.mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", spi.mosi); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_tests++; if (rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_result: got %h expected 0", rsp_result); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    reset = 1'b0;
  endtask

  task automatic test_shl();
    logic [31:0] res; int lat, rises;
    do_req(4'b0110, 32'h0000_0001, 32'd4, res, lat, rises);
    n_tests++; if (res !== 32'h0000_0010) begin n_fail++; $display("FAIL shl_result: got %h expected 00000010", res); end
    n_tests++; if (lat != 813) begin n_fail++; $display("FAIL shl_latency: got %0d expected 813", lat); end
    n_tests++; if (rises != 100) begin n_fail++; $display("FAIL shl_sclk_rises: got %0d expected 100", rises); end
  endtask

  task automatic test_shr();
    logic [31:0] res; int lat, rises;
    do_req(4'b0111, 32'h8000_0000, 32'd31, res, lat, rises);
    n_tests++; if (res !== 32'h0000_0001) begin n_fail++; $display("FAIL shr31_result: got %h expected 00000001", res); end
    n_tests++; if (lat != 813) begin n_fail++; $display("FAIL shr31_latency: got %0d expected 813", lat); end
    do_req(4'b0111, 32'h8000_0000, 32'h0000_0021, res, lat, rises);
    n_tests++; if (res !== 32'h4000_0000) begin n_fail++; $display("FAIL shr_amount_wrap: got %h expected 40000000", res); end
  endtask

  task automatic test_passthrough();
    logic [31:0] res; int lat, rises;
    do_req(4'b0000, 32'hDEAD_BEEF, 32'd7, res, lat, rises);
    n_tests++; if (res !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL passthrough_result: got %h expected deadbeef", res); end
    n_tests++; if (rises != 100) begin n_fail++; $display("FAIL passthrough_rises: got %0d expected 100", rises); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [3];
    logic [31:0] as  [3];
    logic [31:0] bs  [3];
    logic [31:0] exp [3];
    int n_acc, n_rsp, hi, min_hi, ready_bad, cyc, rsp0;
    bit seen_low, load_next, prev_nss;
    ops[0] = 4'b0110; as[0] = 32'h0000_0003; bs[0] = 32'd2; exp[0] = 32'h0000_000C;
    ops[1] = 4'b0111; as[1] = 32'h0000_00F0; bs[1] = 32'd4; exp[1] = 32'h0000_000F;
    ops[2] = 4'b0110; as[2] = 32'h8000_0001; bs[2] = 32'd1; exp[2] = 32'h0000_0002;
    n_acc = 0; n_rsp = 0; hi = 0; min_hi = 1000; ready_bad = 0;
    seen_low = 0; load_next = 0; prev_nss = 1;
    @(negedge clock);
    rsp0 = rsp_total;
    req_valid = 1'b1; req_opcode = ops[0]; req_a = as[0]; req_b = bs[0];
    for (cyc = 0; cyc < 3000 && n_rsp < 3; cyc++) begin
      if (load_next) begin
        load_next = 0;
        if (n_acc < 3) begin req_opcode = ops[n_acc]; req_a = as[n_acc]; req_b = bs[n_acc]; end
        else req_valid = 1'b0;
      end
      if (spi.nss === 1'b1) hi++;
      else begin
        if (prev_nss && seen_low && hi < min_hi) min_hi = hi;
        seen_low = 1; hi = 0;
      end
      prev_nss = (spi.nss === 1'b1);
      if (spi.nss === 1'b0 && req_ready !== 1'b0) ready_bad++;
      if (rsp_valid === 1'b1) begin
        n_tests++;
        if (rsp_result !== exp[n_rsp]) begin
          n_fail++; $display("FAIL b2b_result_%0d: got %h expected %h", n_rsp, rsp_result, exp[n_rsp]);
        end
        n_rsp++;
      end
      if (req_valid && req_ready) begin n_acc++; load_next = 1; end
      @(negedge clock);
    end
    req_valid = 1'b0;
    n_tests++; if (n_rsp != 3) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d expected 3", n_rsp); end
    n_tests++; if (rsp_total - rsp0 != 3) begin n_fail++; $display("FAIL b2b_rsp_pulses: got %0d expected 3", rsp_total - rsp0); end
    n_tests++; if (min_hi < 5) begin n_fail++; $display("FAIL b2b_nss_gap: got %0d expected >=5", min_hi); end
    n_tests++; if (ready_bad != 0) begin n_fail++; $display("FAIL b2b_ready_in_frame: got %0d expected 0", ready_bad); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; int lat, rises, cyc, rsp0;
    @(negedge clock);
    rsp0 = rsp_total;
    req_valid = 1'b1; req_opcode = 4'b0110; req_a = 32'h0000_FFFF; req_b = 32'd3;
    cyc = 0;
    while (!req_ready && cyc < 100) begin @(negedge clock); cyc++; end
    @(negedge clock);
    req_valid = 1'b0;
    cyc = 1;
    // bit 30 of SHIFT_OUT: low phase cycles 245..248, high phase 249..252
    while (cyc < 250) begin @(negedge clock); cyc++; end
    n_tests++; if (dbg_state !== ST_SHIFT_OUT) begin n_fail++; $display("FAIL mid_state_before: got %0d expected %0d", dbg_state, ST_SHIFT_OUT); end
    n_tests++; if (spi.sclk !== 1'b1) begin n_fail++; $display("FAIL mid_sclk_before: got %b expected 1", spi.sclk); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_tests++; if (spi.nss !== 1'b1) begin n_fail++; $display("FAIL mid_nss: got %b expected 1", spi.nss); end
    n_tests++; if (spi.sclk !== 1'b0) begin n_fail++; $display("FAIL mid_sclk: got %b expected 0", spi.sclk); end
    n_tests++; if (spi.mosi !== 1'b0) begin n_fail++; $display("FAIL mid_mosi: got %b expected 0", spi.mosi); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_req_ready: got %b expected 1", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid: got %b expected 0", rsp_valid); end
    do_req(4'b0110, 32'h0000_000F, 32'd1, res, lat, rises);
    n_tests++; if (res !== 32'h0000_001E) begin n_fail++; $display("FAIL mid_next_result: got %h expected 0000001e", res); end
    n_tests++; if (lat != 813) begin n_fail++; $display("FAIL mid_next_latency: got %0d expected 813", lat); end
    @(negedge clock);
    n_tests++; if (rsp_total - rsp0 != 1) begin n_fail++; $display("FAIL mid_rsp_pulses: got %0d expected 1", rsp_total - rsp0); end
  endtask

`ifdef SPI_SHIFT_MASTER_ABORT_EN
  task automatic test_abort();
    logic [31:0] res; int lat, rises, cyc, rsp0;
    @(negedge clock);
    rsp0 = rsp_total;
    req_valid = 1'b1; req_opcode = 4'b0110; req_a = 32'h0000_0001; req_b = 32'd1;
    cyc = 0;
    while (!req_ready && cyc < 100) begin @(negedge clock); cyc++; end
    @(negedge clock);
    req_valid = 1'b0;
    cyc = 0;
    while (dbg_state !== ST_SHIFT_IN && cyc < 2000) begin @(negedge clock); cyc++; end
    n_tests++; if (dbg_state !== ST_SHIFT_IN) begin n_fail++; $display("FAIL abort_reach_shift_in: got %0d expected %0d", dbg_state, ST_SHIFT_IN); end
    repeat (13) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    n_tests++; if (aborted_pulse !== 1'b1) begin n_fail++; $display("FAIL abort_pulse: got %b expected 1", aborted_pulse); end
    n_tests++; if (spi.nss !== 1'b1) begin n_fail++; $display("FAIL abort_nss: got %b expected 1", spi.nss); end
    n_tests++; if (spi.sclk !== 1'b0) begin n_fail++; $display("FAIL abort_sclk: got %b expected 0", spi.sclk); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL abort_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    @(negedge clock);
    n_tests++; if (aborted_pulse !== 1'b0) begin n_fail++; $display("FAIL abort_pulse_width: got %b expected 0", aborted_pulse); end
    repeat (20) @(negedge clock);
    n_tests++; if (rsp_total != rsp0) begin n_fail++; $display("FAIL abort_no_rsp: got %0d expected %0d", rsp_total, rsp0); end
    do_req(4'b0111, 32'h0000_0100, 32'd8, res, lat, rises);
    n_tests++; if (res !== 32'h0000_0001) begin n_fail++; $display("FAIL abort_next_result: got %h expected 00000001", res); end
  endtask
`endif

  initial begin
    test_reset();
    test_shl();
    test_shr();
    test_passthrough();
    test_back_to_back();
    test_reset_mid();
`ifdef SPI_SHIFT_MASTER_ABORT_EN
    test_abort();
`endif
    repeat (5) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
